// File: rtl/lock_detector.sv
// Lock detector: registered |error| magnitude feeding a hysteretic lock FSM with dwell counting.
// Optional loss-event counter built only when LOCK_DET_LOSS_COUNT_EN is defined.
module lock_detector #(
  parameter int unsigned in_bits  = 16,
  parameter int unsigned cnt_bits = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [in_bits-1:0]  in_data,
  input  logic                       in_valid,
  input  logic [in_bits-2:0]         thresh_lock,
  input  logic [in_bits-2:0]         thresh_unlock,
  input  logic [cnt_bits-1:0]        dwell_lock,
  input  logic [cnt_bits-1:0]        dwell_unlock,
  output logic                       locked,
  output logic [1:0]                 state,
  output logic                       lost_pulse,
  output logic [in_bits-2:0]         mag,
  output logic [15:0]                loss_count
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [in_bits-1:0]  MOST_NEG = {1'b1, {(in_bits-1){1'b0}}};
  localparam logic [in_bits-1:0]  IN_ONE   = {{(in_bits-1){1'b0}}, 1'b1};
  localparam logic [cnt_bits-1:0] CNT_ONE  = {{(cnt_bits-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [cnt_bits-1:0] cnt_q, cnt_d;
  logic                lost_pulse_q, lost_pulse_d;
  logic [in_bits-2:0]  mag_q, mag_d;
  logic                vld_q, vld_d;

  logic [in_bits-1:0]  in_u;
  logic [in_bits-1:0]  neg;
  logic [cnt_bits-1:0] cnt_inc;
  logic [cnt_bits-1:0] dl_eff;
  logic [cnt_bits-1:0] du_eff;
  logic                in_lock;
  logic                out_lock;

  // Stage 1: magnitude, with the most negative code clamped to the largest positive magnitude
  always_comb begin
    in_u  = in_data;
    neg   = (~in_u) + IN_ONE;
    mag_d = mag_q;
    vld_d = in_valid;
    if (in_valid) begin
      if (in_u == MOST_NEG) begin
        mag_d = '1;
      end else if (in_u[in_bits-1]) begin
        mag_d = neg[in_bits-2:0];
      end else begin
        mag_d = in_u[in_bits-2:0];
      end
    end
  end

  // Stage 2: lock FSM evaluated only on samples qualified by the delayed valid
  always_comb begin
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    dl_eff       = (dwell_lock   == '0) ? CNT_ONE : dwell_lock;
    du_eff       = (dwell_unlock == '0) ? CNT_ONE : dwell_unlock;
    in_lock      = mag_q < thresh_lock;
    out_lock     = mag_q > thresh_unlock;
    state_d      = state_q;
    cnt_d        = cnt_q;
    lost_pulse_d = 1'b0;
    if (vld_q) begin
      unique case (state_q)
        UNLOCKED: begin
          cnt_d = '0;
          if (in_lock) begin
            if (dl_eff <= CNT_ONE) begin
              state_d = LOCKED;
            end else begin
              state_d = ACQUIRE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ACQUIRE: begin
          if (in_lock) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= dl_eff) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end
          end else begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          cnt_d = '0;
          if (out_lock) begin
            if (du_eff <= CNT_ONE) begin
              state_d      = UNLOCKED;
              lost_pulse_d = 1'b1;
            end else begin
              state_d = HOLD;
              cnt_d   = CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (out_lock) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= du_eff) begin
              state_d      = UNLOCKED;
              cnt_d        = '0;
              lost_pulse_d = 1'b1;
            end
          end else begin
            state_d = LOCKED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      cnt_q        <= '0;
      lost_pulse_q <= 1'b0;
      mag_q        <= '0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_pulse_q <= lost_pulse_d;
      mag_q        <= mag_d;
      vld_q        <= vld_d;
    end
  end

`ifdef LOCK_DET_LOSS_COUNT_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lost_pulse_d && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_count = loss_cnt_q;
`else
  assign loss_count = '0;
`endif

  assign state      = state_q;
  assign locked     = (state_q == LOCKED) || (state_q == HOLD);
  assign lost_pulse = lost_pulse_q;
  assign mag        = mag_q;

endmodule

// File: tb/tb_lock_detector.sv
// Scoreboard bench for lock_detector: stimulus pushes expectations, a monitor pops them
// one edge (mag) and two edges (state/locked/lost_pulse/loss_count) after each valid sample.
module tb_lock_detector;

  logic               clk;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic [14:0]        thresh_lock;
  logic [14:0]        thresh_unlock;
  logic [15:0]        dwell_lock;
  logic [15:0]        dwell_unlock;
  logic               locked;
  logic [1:0]         state;
  logic               lost_pulse;
  logic [14:0]        mag;
  logic [15:0]        loss_count;

  lock_detector #(.in_bits(16), .cnt_bits(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .thresh_lock   (thresh_lock),
    .thresh_unlock (thresh_unlock),
    .dwell_lock    (dwell_lock),
    .dwell_unlock  (dwell_unlock),
    .locked        (locked),
    .state         (state),
    .lost_pulse    (lost_pulse),
    .mag           (mag),
    .loss_count    (loss_count)
  );

  typedef struct {
    logic [1:0]  st;
    logic        lk;
    logic        lp;
    logic [15:0] lc;
  } exp_t;

  exp_t        sq[$];
  logic [14:0] mq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_loss = 0;
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] loss_exp(input int n);
`ifdef LOCK_DET_LOSS_COUNT_EN
    return n[15:0];
`else
    return (n > 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One valid sample; expected results are hand-computed at the call site
  task automatic send(input int data, input int exp_mag, input int exp_st, input bit exp_lp);
    exp_t e;
    in_data  = 16'(data);
    in_valid = 1'b1;
    if (exp_lp) exp_loss++;
    e.st = 2'(exp_st);
    e.lk = (exp_st >= 2);
    e.lp = exp_lp;
    e.lc = loss_exp(exp_loss);
    mq.push_back(15'(exp_mag));
    sq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 = 1'b0;
      v2 = 1'b0;
    end else begin
      v2 = v1;
      v1 = in_valid;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v1) begin
      if (mq.size() == 0) chk("mag_queue_underflow", 1, 0);
      else chk("mag", int'(mag), int'(mq.pop_front()));
    end
    if (v2) begin
      if (sq.size() == 0) begin
        chk("state_queue_underflow", 1, 0);
      end else begin
        e = sq.pop_front();
        chk("state", int'(state), int'(e.st));
        chk("locked", int'(locked), int'(e.lk));
        chk("lost_pulse", int'(lost_pulse), int'(e.lp));
        chk("loss_count", int'(loss_count), int'(e.lc));
      end
    end else begin
      chk("lost_pulse_idle", int'(lost_pulse), 0);
    end
  end

  initial begin
    int guard;
    rst           = 1'b1;
    in_data       = '0;
    in_valid      = 1'b0;
    thresh_lock   = 15'd100;
    thresh_unlock = 15'd200;
    dwell_lock    = 16'd4;
    dwell_unlock  = 16'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_mag", int'(mag), 0);
    chk("rst_loss_count", int'(loss_count), 0);
    rst = 1'b0;
    idle(2);

    // Acquisition with dwell 4
    send(50, 50, 1, 0);
    send(50, 50, 1, 0);
    send(50, 50, 1, 0);
    send(50, 50, 2, 0);
    idle(3);

    // Hold, recovery at 150 (neither in nor out), then loss after three out-of-lock samples
    send(300, 300, 3, 0);
    send(300, 300, 3, 0);
    send(150, 150, 2, 0);
    send(300, 300, 3, 0);
    send(300, 300, 3, 0);
    send(300, 300, 0, 1);
    idle(3);

    // Saturating magnitude and strict comparisons
    send(-32768, 32767, 0, 0);
    send(100, 100, 0, 0);
    send(-99, 99, 1, 0);
    send(-200, 200, 0, 0);
    idle(2);

    // Dwell 0 acts as 1; equality with thresh_unlock keeps lock
    dwell_lock   = 16'd0;
    dwell_unlock = 16'd0;
    send(10, 10, 2, 0);
    send(200, 200, 2, 0);
    send(-201, 201, 0, 1);
    idle(2);

    // Dwell change mid-acquisition applies to the next sample without clearing the count
    dwell_lock = 16'd4;
    send(50, 50, 1, 0);
    send(50, 50, 1, 0);
    idle(4);
    dwell_lock = 16'd3;
    send(50, 50, 2, 0);
    idle(2);
    send(1000, 1000, 0, 1);
    dwell_lock = 16'd0;
    send(0, 0, 2, 0);
    idle(3);
    chk("loss_count_three", int'(loss_count), int'(loss_exp(3)));

    // Reset asserted mid-hold
    dwell_unlock = 16'd3;
    send(300, 300, 3, 0);
    send(300, 300, 3, 0);
    idle(2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_loss = 0;
    #1;
    chk("midhold_rst_state", int'(state), 0);
    chk("midhold_rst_locked", int'(locked), 0);
    chk("midhold_rst_lost", int'(lost_pulse), 0);
    chk("midhold_rst_loss_count", int'(loss_count), 0);
    chk("midhold_rst_mag", int'(mag), 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // First sample after reset evaluated from UNLOCKED
    dwell_lock = 16'd4;
    send(50, 50, 1, 0);
    send(300, 300, 0, 0);

    guard = 0;
    while ((sq.size() != 0 || mq.size() != 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    idle(2);
    chk("queues_drained", sq.size() + mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
